timer_irq_sched: RTL
====================

TIMER_IRQ_SCHED -- requirements
Module: timer_irq_sched

Interface
REQ-001 Parameter NSRC, default 4, SHALL set the number of timer interrupt sources, with legal range 2..8.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-004 Port Addr, input, [31:2], SHALL be the word address; only Addr[3:2] is decoded.
REQ-005 Port WE, input, 1 bit, SHALL be the register write enable.
REQ-006 Port Din, input, 32 bits, SHALL be the write data.
REQ-007 Port Dout, output, 32 bits, SHALL be the combinational read data for Addr[3:2].
REQ-008 Port irq_in, input, NSRC bits, SHALL carry the level IRQ outputs of the timer blocks.
REQ-009 Port irq_out, output, 1 bit, SHALL be the interrupt request to the CPU.
REQ-010 Port irq_id, output, 3 bits, SHALL be the index of the source being serviced.

Function
REQ-011 Register map SHALL be: 0 PEND (read; write-1-to-clear); 1 MASK (read/write, bits [NSRC-1:0]); 2 CUR (read only, {active, 28'b0, id[2:0]}); 3 EOI (write-only, any data; reads as 0).
REQ-012 Unused upper bits SHALL read as 0 and ignore writes.
REQ-013 A rising edge of irq_in[i] (registered previous value 0, current 1) SHALL set PEND[i] at that clock edge.
REQ-014 A simultaneous edge-set and W1C on the same PEND bit SHALL leave the bit set.
REQ-015 The FSM SHALL have three states: IDLE, ARB and ACTIVE.
REQ-016 IDLE SHALL go to ARB when (PEND & MASK) != 0.
REQ-017 ARB SHALL select a winner, load irq_id, clear that source's PEND bit and go to ACTIVE in one cycle.
REQ-018 If (PEND & MASK) becomes 0 during ARB, the FSM SHALL return to IDLE and irq_id SHALL be unchanged.
REQ-019 irq_out SHALL equal (state == ACTIVE), registered, giving 2 cycles from PEND visible to irq_out high.
REQ-020 ACTIVE SHALL exit to IDLE only on a write to EOI; irq_out SHALL drop the next cycle.
REQ-021 An EOI write outside ACTIVE SHALL be ignored.
REQ-022 MASK or PEND changes during ACTIVE SHALL NOT abort service.
REQ-023 A new edge on the serviced source during ACTIVE SHALL re-set its PEND bit.
REQ-024 Fixed-priority arbitration (default) SHALL grant the lowest set index of (PEND & MASK).

Reset
REQ-025 Assertion of reset SHALL immediately clear PEND, MASK (all sources masked), the irq_in history, state (to IDLE), irq_id (to 0) and irq_out (to 0), including mid-ACTIVE.
REQ-026 After reset release, a level already high on irq_in SHALL count as a rising edge on the first clock.

Configuration
REQ-027 With TIMER_IRQ_SCHED_RR_EN defined, arbitration SHALL be round-robin: search starts at (last granted id + 1) mod NSRC, and the pointer resets to 0.
REQ-028 With TIMER_IRQ_SCHED_RR_EN undefined, arbitration SHALL use the fixed priority of REQ-024 and no pointer register SHALL exist.

Structure
REQ-029 A shared package SHALL hold the register offsets (PEND/MASK/CUR/EOI), the FSM state encodings and the id width (3).
REQ-030 The winner selection SHALL be one sub-module, irq_prio_pick (fixed or rotating priority encoder), instantiated once.

Verification
REQ-031 Reset low mid-ACTIVE, then released -> irq_out 0, PEND 0, MASK 0, CUR reads 0 immediately.
REQ-032 MASK=4'hF, rising edge on irq_in[2] at edge k -> PEND=4'h4 after k; irq_out=1, irq_id=2 after k+2; EOI write -> irq_out 0 next cycle.
REQ-033 MASK=4'hF, simultaneous edges on irq_in[3] and irq_in[1] -> fixed mode grants 1, then 3 after EOI; RR mode with pointer after 1 grants 3 before 1 on repeat.
REQ-034 MASK=4'h0, edge on irq_in[0] -> PEND=1, irq_out stays 0; then MASK=1 -> irq_out=1 two cycles later.
REQ-035 Same-cycle W1C of PEND bit 0 and edge on irq_in[0] -> PEND[0] remains 1.
REQ-036 EOI write in IDLE, and MASK cleared during ACTIVE -> respectively no state change, and irq_out held until EOI.

Source files
------------

// File: rtl/timer_irq_sched_pkg.sv
// Shared definitions for the timer interrupt scheduler: register offsets,
// FSM state encodings and the width of the serviced-source id.
package timer_irq_sched_pkg;

  // Width of irq_id and of the CUR id field (supports up to 8 sources)
  localparam int ID_W = 3;

  // Word offsets decoded from Addr[3:2]
  localparam logic [1:0] REG_PEND = 2'd0;
  localparam logic [1:0] REG_MASK = 2'd1;
  localparam logic [1:0] REG_CUR  = 2'd2;
  localparam logic [1:0] REG_EOI  = 2'd3;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/timer_irq_sched_prio_pick.sv
// Winner selection for the timer interrupt scheduler. Grants the request
// closest to i_start when walking upward with wrap-around. With i_start
// held at 0 this is a plain lowest-index fixed priority encoder.
module irq_prio_pick
  import timer_irq_sched_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic [NSRC-1:0] i_req,
  input  logic [ID_W-1:0] i_start,
  output logic            o_valid,
  output logic [ID_W-1:0] o_id
);

  int w_dist;
  int w_best;

  // Pick the requesting source with the smallest rotated distance from i_start
  always_comb begin
    w_dist  = 0;
    w_best  = NSRC;
    o_id    = '0;
    o_valid = |i_req;
    for (int i = 0; i < NSRC; i++) begin
      w_dist = i - int'(i_start);
      if (w_dist < 0) w_dist = w_dist + NSRC;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_id   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/timer_irq_sched.sv
// Timer interrupt scheduler: edge-captures timer IRQ levels into PEND,
// arbitrates over PEND & MASK and services one source at a time until
// the CPU writes EOI.
// Optional feature: define TIMER_IRQ_SCHED_RR_EN for round-robin
// arbitration (default build is lowest-index fixed priority).
//
// Bus handshake: single-cycle register port with no valid/ready. A write
// takes effect at the rising edge where WE=1; Dout is combinational from
// Addr[3:2] and the current register state.
module timer_irq_sched
  import timer_irq_sched_pkg::*;
#(
  parameter int NSRC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:2]     Addr,
  input  logic            WE,
  input  logic [31:0]     Din,
  output logic [31:0]     Dout,
  input  logic [NSRC-1:0] irq_in,
  output logic            irq_out,
  output logic [ID_W-1:0] irq_id,
  output logic [1:0]      o_dbg_state
);

  state_t            r_state;
  logic [NSRC-1:0]   r_pend;
  logic [NSRC-1:0]   r_mask;
  logic [NSRC-1:0]   r_irq_prev;
  logic [ID_W-1:0]   r_irq_id;
  logic              r_irq_out;

  logic [1:0]        w_addr;
  logic              w_wr_pend;
  logic              w_wr_mask;
  logic              w_wr_eoi;
  logic [NSRC-1:0]   w_edge;
  logic [NSRC-1:0]   w_req;
  logic [NSRC-1:0]   w_w1c;
  logic [NSRC-1:0]   w_arb_clr;
  logic [ID_W-1:0]   w_start;
  logic              w_pick_valid;
  logic [ID_W-1:0]   w_pick_id;
  logic              w_grant;
  logic              w_unused_ok;

  assign w_addr    = Addr[3:2];
  assign w_wr_pend = WE && (w_addr == REG_PEND);
  assign w_wr_mask = WE && (w_addr == REG_MASK);
  assign w_wr_eoi  = WE && (w_addr == REG_EOI);
  assign w_edge    = irq_in & ~r_irq_prev;
  assign w_req     = r_pend & r_mask;
  assign w_w1c     = w_wr_pend ? Din[NSRC-1:0] : '0;
  assign w_grant   = (r_state == ST_ARB) && w_pick_valid;

  // Only Addr[3:2] and Din[NSRC-1:0] carry meaning
  assign w_unused_ok = &{1'b0, Addr[31:4], Din[31:NSRC]};

`ifdef TIMER_IRQ_SCHED_RR_EN
  logic [ID_W-1:0] r_rr_ptr;

  // Round-robin pointer: next search starts just past the last grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= (w_pick_id == ID_W'(NSRC - 1)) ? '0 : (w_pick_id + 1'b1);
    end
  end

  assign w_start = r_rr_ptr;
`else
  assign w_start = '0;
`endif

  irq_prio_pick #(
    .NSRC (NSRC)
  ) u_pick (
    .i_req   (w_req),
    .i_start (w_start),
    .o_valid (w_pick_valid),
    .o_id    (w_pick_id)
  );

  // One-hot clear of the winning source's PEND bit on grant
  always_comb begin
    w_arb_clr = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_grant && (w_pick_id == ID_W'(i))) w_arb_clr[i] = 1'b1;
    end
  end

  // PEND/MASK/history: a new edge always wins over W1C or grant clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend     <= '0;
      r_mask     <= '0;
      r_irq_prev <= '0;
    end else begin
      r_irq_prev <= irq_in;
      r_pend     <= (r_pend & ~w_w1c & ~w_arb_clr) | w_edge;
      if (w_wr_mask) r_mask <= Din[NSRC-1:0];
    end
  end

  // Scheduler FSM with registered irq_out and irq_id
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_irq_id  <= '0;
      r_irq_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req) r_state <= ST_ARB;
        end
        ST_ARB: begin
          if (w_pick_valid) begin
            r_irq_id  <= w_pick_id;
            r_irq_out <= 1'b1;
            r_state   <= ST_ACTIVE;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (w_wr_eoi) begin
            r_irq_out <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_irq_out <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Combinational register read mux
  always_comb begin
    Dout = '0;
    case (w_addr)
      REG_PEND: Dout = {{(32 - NSRC){1'b0}}, r_pend};
      REG_MASK: Dout = {{(32 - NSRC){1'b0}}, r_mask};
      REG_CUR:  Dout = {(r_state == ST_ACTIVE), 28'b0, r_irq_id};
      default:  Dout = '0;
    endcase
  end

  assign irq_out     = r_irq_out;
  assign irq_id      = r_irq_id;
  assign o_dbg_state = r_state;

endmodule
